// File: rtl/g5_apblink_pkg.sv
// g5_apblink_pkg: shared encodings for the APBLink slave.
//   cmd_e      link command, sampled from lnk_s_addr[1:0] in IDLE
//   state_e    slave FSM states
//   lane_vec_t 4 lanes x 8 beats: the serial view of a 32-bit word, where
//              lane j beat k is word bit 8j+k
package g5_apblink_pkg;

  typedef enum logic [1:0] {
    CMD_NOOP  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_POLL  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SETUP,
    ST_ACCESS,
    ST_RDY,
    ST_RDAT
  } state_e;

  localparam int RDY_BIT    = 2;
  localparam int ERR_BIT    = 3;
  localparam int LNK_BEATS  = 8;
  localparam int NUM_LANES  = 4;          // data lanes on lnk_s_wdata / lnk_s_rdata
  localparam int ADDR_LANES = 3;          // address lanes on lnk_s_addr
  localparam int VEC_W      = LNK_BEATS;  // one bit per beat per lane

  typedef logic [NUM_LANES-1:0][VEC_W-1:0] lane_vec_t;

  // Marker word shown on lnk_s_rdata during the RDY cycle.
  function automatic logic [3:0] rdy_marker(input logic err);
    logic [3:0] m;
    m          = '0;
    m[RDY_BIT] = 1'b1;
    m[ERR_BIT] = err;
    return m;
  endfunction

endpackage

// File: rtl/g5_apblink_lane_shift.sv
// g5_apblink_lane_shift: beat counter plus per-lane shift register.
// Every lane shifts right with its serial bit entering at the MSB, so after
// VEC_W shifts the first beat sits in bit 0. The same direction serialises:
// ser[] always exposes bit 0, i.e. the next beat to send.
//   pclk, preset_b  clock, synchronous active-low reset
//   clr             clear beat counter (priority over step)
//   step            advance beat counter
//   shift           shift every lane by one beat, shift_in entering at MSB
//   load/load_val   parallel load (priority over shift)
//   vec             parallel word
//   ser             bit 0 of every lane
//   beat_last       beat counter is at its final beat
module g5_apblink_lane_shift #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic                              pclk,
  input  logic                              preset_b,
  input  logic                              clr,
  input  logic                              step,
  input  logic                              shift,
  input  logic                              load,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]   load_val,
  input  logic [NUM_LANES-1:0]              shift_in,
  output logic [NUM_LANES-1:0][VEC_W-1:0]   vec,
  output logic [NUM_LANES-1:0]              ser,
  output logic                              beat_last
);

  localparam int CW = $clog2(VEC_W);

  logic [CW-1:0] beat;

  always_ff @(posedge pclk) begin
    if (!preset_b)  beat <= '0;
    else if (clr)   beat <= '0;
    else if (step)  beat <= beat + 1'b1;
  end

  assign beat_last = (beat == CW'(VEC_W - 1));

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    logic [VEC_W-1:0] lane_q;

    always_ff @(posedge pclk) begin
      if (!preset_b)  lane_q <= '0;
      else if (load)  lane_q <= load_val[j];
      else if (shift) lane_q <= {shift_in[j], lane_q[VEC_W-1:1]};
    end

    assign vec[j] = lane_q;
    assign ser[j] = lane_q[0];
  end

endmodule

// File: rtl/g5_apblink_slave.sv
// g5_apblink_slave: fabric end of the APBLink serial link.
// Deserialises a link command (CMD, 8 beats of ADDR/WDATA), runs one APB4
// transfer, then returns a RDY marker and, for reads, 8 beats of read data.
//   pclk, preset_b                clock (also link clock), sync active-low reset
//   lnk_s_enable                  link enable, qualifies commands in IDLE
//   lnk_s_addr[2:0]               CMD in command cycle, then address bits
//   lnk_s_wdata[3:0]              PSTRB in command cycle, then write data bits
//   lnk_s_rdata[3:0]              RDY/ERR markers, then read data bits
//   m_psel/m_penable/m_pwrite     APB4 controls
//   m_paddr[25:0], m_pwdata[31:0], m_pstrb[3:0]   APB4 request
//   m_prdata[31:0], m_pready, m_pslverr           APB4 response
//   lnk_busy                      high whenever the FSM is not in IDLE
module g5_apblink_slave
  import g5_apblink_pkg::*;
#(
  parameter int unsigned APB_TIMEOUT = 256
) (
  input  logic        pclk,
  input  logic        preset_b,
  input  logic        lnk_s_enable,
  input  logic [2:0]  lnk_s_addr,
  input  logic [3:0]  lnk_s_wdata,
  output logic [3:0]  lnk_s_rdata,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [25:0] m_paddr,
  output logic [31:0] m_pwdata,
  output logic [3:0]  m_pstrb,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  input  logic        m_pslverr,
  output logic        lnk_busy
);

  localparam int TW = (APB_TIMEOUT == 0) ? 1 : $clog2(APB_TIMEOUT + 1);

  state_e                              state;
  cmd_e                                cmd_q;
  cmd_e                                cmd_in;
  logic [3:0]                          strb_q;
  logic [ADDR_LANES-1:0][VEC_W-1:0]    addr_q;
  logic [ADDR_LANES-1:0][VEC_W-1:0]    addr_nxt;
  logic [ADDR_LANES*VEC_W-1:0]         last_addr;
  logic [TW-1:0]                       tmo_cnt;
  logic                                tmo_hit;
  logic                                acc_done;
  logic                                acc_err;

  lane_vec_t                           sh_vec;
  lane_vec_t                           sh_load_val;
  logic [NUM_LANES-1:0]                sh_ser;
  logic [NUM_LANES-1:0]                sh_in;
  logic                                sh_step;
  logic                                sh_shift;
  logic                                sh_load;
  logic                                beat_last;

  assign cmd_in = cmd_e'(lnk_s_addr[1:0]);

  // Address lanes shift like the data lanes: beat k lands in bit k.
  always_comb begin
    addr_nxt = addr_q;
    for (int i = 0; i < ADDR_LANES; i++)
      addr_nxt[i] = {lnk_s_addr[i], addr_q[i][VEC_W-1:1]};
  end

  // Abort on the APB_TIMEOUT-th ACCESS cycle that still has no m_pready.
  assign tmo_hit  = (APB_TIMEOUT != 0) && !m_pready &&
                    (tmo_cnt == TW'(APB_TIMEOUT - 1));
  assign acc_done = m_pready || tmo_hit;
  assign acc_err  = m_pready ? m_pslverr : 1'b1;

  // The data shifter deserialises WDATA in ADDR, holds it through ACCESS,
  // then is reloaded with the response and serialised out from RDY onward.
  // Shifting in RDY puts beat 1 at the output tap for the first RDAT cycle.
  assign sh_step     = (state == ST_ADDR) || (state == ST_RDAT);
  assign sh_shift    = sh_step || ((state == ST_RDY) && (cmd_q != CMD_WRITE));
  assign sh_load     = (state == ST_ACCESS) && acc_done;
  assign sh_load_val = m_pready ? lane_vec_t'(m_prdata) : '0;
  assign sh_in       = (state == ST_ADDR) ? lnk_s_wdata : '0;

  g5_apblink_lane_shift #(
    .NUM_LANES (NUM_LANES),
    .VEC_W     (VEC_W)
  ) u_shift (
    .pclk      (pclk),
    .preset_b  (preset_b),
    .clr       (state == ST_IDLE),
    .step      (sh_step),
    .shift     (sh_shift),
    .load      (sh_load),
    .load_val  (sh_load_val),
    .shift_in  (sh_in),
    .vec       (sh_vec),
    .ser       (sh_ser),
    .beat_last (beat_last)
  );

  assign m_paddr  = {addr_q, 2'b00};
  assign m_pwdata = sh_vec;

  always_ff @(posedge pclk) begin
    if (!preset_b) begin
      state       <= ST_IDLE;
      cmd_q       <= CMD_NOOP;
      strb_q      <= '0;
      addr_q      <= '0;
      last_addr   <= '0;
      tmo_cnt     <= '0;
      m_psel      <= 1'b0;
      m_penable   <= 1'b0;
      m_pwrite    <= 1'b0;
      m_pstrb     <= '0;
      lnk_s_rdata <= '0;
      lnk_busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lnk_s_enable) begin
            case (cmd_in)
              CMD_WRITE, CMD_READ: begin
                state    <= ST_ADDR;
                cmd_q    <= cmd_in;
                strb_q   <= lnk_s_wdata;
                lnk_busy <= 1'b1;
              end
              CMD_POLL: begin
                state    <= ST_SETUP;
                cmd_q    <= cmd_in;
                strb_q   <= lnk_s_wdata;
                addr_q   <= last_addr;
                m_psel   <= 1'b1;
                m_pwrite <= 1'b0;
                m_pstrb  <= '0;
                lnk_busy <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        ST_ADDR: begin
          addr_q <= addr_nxt;
          if (beat_last) begin
            state     <= ST_SETUP;
            last_addr <= addr_nxt;
            m_psel    <= 1'b1;
            m_pwrite  <= (cmd_q == CMD_WRITE);
            m_pstrb   <= (cmd_q == CMD_WRITE) ? strb_q : 4'h0;
          end
        end

        ST_SETUP: begin
          state     <= ST_ACCESS;
          m_penable <= 1'b1;
          tmo_cnt   <= '0;
        end

        ST_ACCESS: begin
          if (acc_done) begin
            state       <= ST_RDY;
            m_psel      <= 1'b0;
            m_penable   <= 1'b0;
            m_pwrite    <= 1'b0;
            m_pstrb     <= '0;
            lnk_s_rdata <= rdy_marker(acc_err);
          end else if (!(&tmo_cnt)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_RDY: begin
          if (cmd_q == CMD_WRITE) begin
            state       <= ST_IDLE;
            lnk_s_rdata <= '0;
            lnk_busy    <= 1'b0;
          end else begin
            state       <= ST_RDAT;
            lnk_s_rdata <= sh_ser;
          end
        end

        ST_RDAT: begin
          if (beat_last) begin
            state       <= ST_IDLE;
            lnk_s_rdata <= '0;
            lnk_busy    <= 1'b0;
          end else begin
            lnk_s_rdata <= sh_ser;
          end
        end

        default: begin
          state    <= ST_IDLE;
          lnk_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_g5_apblink_slave.sv
// tb_g5_apblink_slave: drives the link as the master would, answers APB as a
// memory-backed slave, and checks against a transaction-level model.
module tb_g5_apblink_slave;

  localparam int TMO = 4;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_POLL  = 2'b11;
  localparam logic [25:0] A_WR = 26'h3006150;
  localparam logic [25:0] A_RD = 26'h0001234;

  logic        pclk = 1'b0;
  logic        preset_b = 1'b0;
  logic        lnk_s_enable = 1'b0;
  logic [2:0]  lnk_s_addr = '0;
  logic [3:0]  lnk_s_wdata = '0;
  logic [3:0]  lnk_s_rdata;
  logic        m_psel, m_penable, m_pwrite;
  logic [25:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic [31:0] m_prdata = '0;
  logic        m_pready = 1'b0;
  logic        m_pslverr = 1'b0;
  logic        lnk_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [23:0]];
  logic [23:0] last_a = '0;

  g5_apblink_slave #(.APB_TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset_b(preset_b), .lnk_s_enable(lnk_s_enable),
    .lnk_s_addr(lnk_s_addr), .lnk_s_wdata(lnk_s_wdata), .lnk_s_rdata(lnk_s_rdata),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .lnk_busy(lnk_busy)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [23:0] ad);
    if (!mem.exists(ad)) mem[ad] = $urandom;
    return mem[ad];
  endfunction

  function automatic void mem_wr(input logic [23:0] ad, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = mem_rd(ad);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    mem[ad] = v;
  endfunction

  // Reset asserted at this negedge; one cycle later everything must be zero.
  task automatic do_reset(input string tag);
    preset_b = 1'b0; lnk_s_enable = 1'b0; lnk_s_addr = '0; lnk_s_wdata = '0; m_pready = 1'b0;
    @(negedge pclk);
    chk({tag, "_ctl"}, 64'({lnk_s_rdata, m_psel, m_penable, m_pwrite, lnk_busy, m_pstrb, m_paddr}), 64'd0);
    chk({tag, "_pwdata"}, 64'(m_pwdata), 64'd0);
    preset_b = 1'b1;
    last_a = '0;
  endtask

  // One link command. rst_phase: 0 none, 1 reset in ADDR beat 3, 2 reset in RDAT beat 5.
  task automatic run_cmd(input logic [1:0] cmd, input logic [23:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input int waits, input logic slverr, input int rst_phase);
    logic [23:0] ea;
    logic [31:0] got, edata;
    int acc, beat, phase;
    bit setup_seen, to;
    ea = (cmd == C_POLL) ? last_a : a;
    to = (waits + 1 > TMO);
    got = '0; edata = '0; acc = 0; beat = 0; phase = 0; setup_seen = 0;
    @(negedge pclk);
    lnk_s_enable = 1'b1; lnk_s_addr = {1'($urandom), cmd}; lnk_s_wdata = st;
    if (cmd != C_POLL) begin
      last_a = a;
      for (int k = 0; k < 8; k++) begin
        @(negedge pclk);
        if (rst_phase == 1 && k == 3) begin do_reset("rst_addr"); return; end
        lnk_s_addr = {a[16+k], a[8+k], a[k]};
        for (int j = 0; j < 4; j++) lnk_s_wdata[j] = wd[8*j+k];
      end
    end
    for (int cyc = 0; cyc < 60 && phase < 3; cyc++) begin
      @(negedge pclk);
      m_pready = 1'b0; m_pslverr = 1'($urandom); m_prdata = $urandom;
      case (phase)
        0: begin
          // stray link traffic while busy must be ignored
          lnk_s_enable = 1'($urandom); lnk_s_addr = 3'($urandom); lnk_s_wdata = 4'($urandom);
          if (m_psel && !m_penable) begin
            setup_seen = 1;
            chk("setup_paddr", 64'(m_paddr), 64'({ea, 2'b00}));
            chk("setup_pwrite", 64'(m_pwrite), 64'(cmd == C_WRITE));
            chk("setup_pstrb", 64'(m_pstrb), 64'((cmd == C_WRITE) ? st : 4'h0));
            if (cmd == C_WRITE) chk("setup_pwdata", 64'(m_pwdata), 64'(wd));
          end else if (m_psel && m_penable) begin
            acc++;
            chk("acc_paddr", 64'(m_paddr), 64'({ea, 2'b00}));
            chk("acc_pstrb", 64'(m_pstrb), 64'((cmd == C_WRITE) ? st : 4'h0));
            if (acc == waits + 1) begin
              m_pready = 1'b1; m_pslverr = slverr;
              m_prdata = slverr ? 32'h0 : mem_rd(m_paddr[25:2]);
              if (m_pwrite && !slverr) mem_wr(m_paddr[25:2], m_pwdata, m_pstrb);
            end
          end else if (lnk_s_rdata != 4'h0) begin
            chk("rdy_marker", 64'(lnk_s_rdata), 64'({to | slverr, 3'b100}));
            chk("acc_cycles", 64'(acc), 64'(to ? TMO : waits + 1));
            chk("rdy_setup_seen", 64'(setup_seen), 64'd1);
            chk("rdy_busy", 64'(lnk_busy), 64'd1);
            edata = (to || slverr) ? 32'h0 : mem_rd(ea);
            lnk_s_enable = 1'b0; lnk_s_addr = '0; lnk_s_wdata = '0;
            phase = (cmd == C_WRITE) ? 2 : 1;
          end
        end
        1: begin
          for (int j = 0; j < 4; j++) got[8*j+beat] = lnk_s_rdata[j];
          beat++;
          if (rst_phase == 2 && beat == 6) begin do_reset("rst_rdat"); return; end
          if (beat == 8) begin chk("rdat_word", 64'(got), 64'(edata)); phase = 2; end
        end
        default: begin
          chk("idle_busy", 64'(lnk_busy), 64'd0);
          chk("idle_rdata", 64'(lnk_s_rdata), 64'd0);
          chk("idle_psel", 64'({m_psel, m_penable}), 64'd0);
          phase = 3;
        end
      endcase
    end
    chk("txn_done", 64'(phase == 3), 64'd1);
  endtask

  initial begin
    repeat (2) @(negedge pclk);
    do_reset("reset");
    mem[A_RD[25:2]] = 32'hDEAD_BEEF;

    run_cmd(C_WRITE, A_WR[25:2], 32'hA5A5_0001, 4'hF, 0, 1'b0, 0);
    run_cmd(C_READ,  A_RD[25:2], 32'h0, 4'h5, 1, 1'b0, 0);
    run_cmd(C_POLL,  24'h0, 32'h0, 4'hF, 2, 1'b0, 0);
    run_cmd(C_READ,  24'h00_0100, 32'h0, 4'h0, 0, 1'b1, 0);
    run_cmd(C_READ,  24'h00_0200, 32'h0, 4'h0, 100, 1'b0, 0);  // timeout
    run_cmd(C_READ,  24'h00_0200, 32'h0, 4'h0, 3, 1'b0, 0);    // ready on last allowed cycle
    run_cmd(C_WRITE, 24'h00_0300, 32'h1234_5678, 4'h3, 100, 1'b0, 0);

    // disabled link and NOOP with addr[2] set are ignored
    @(negedge pclk); lnk_s_enable = 1'b0; lnk_s_addr = {1'b0, C_WRITE};
    @(negedge pclk); chk("en_low_busy", 64'(lnk_busy), 64'd0);
    lnk_s_addr = {1'b1, C_POLL};
    @(negedge pclk); chk("en_low_psel", 64'({lnk_busy, m_psel}), 64'd0);
    lnk_s_enable = 1'b1; lnk_s_addr = 3'b100;
    @(negedge pclk); chk("noop_busy", 64'(lnk_busy), 64'd0);
    lnk_s_enable = 1'b0; lnk_s_addr = '0;

    run_cmd(C_WRITE, A_WR[25:2], 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 1);
    run_cmd(C_WRITE, A_WR[25:2], 32'h0BAD_F00D, 4'hF, 0, 1'b0, 0);
    run_cmd(C_READ,  A_WR[25:2], 32'h0, 4'h0, 0, 1'b0, 0);
    run_cmd(C_READ,  A_RD[25:2], 32'h0, 4'h0, 0, 1'b0, 2);
    run_cmd(C_POLL,  24'h0, 32'h0, 4'h0, 0, 1'b0, 0);          // last_addr cleared by reset

    for (int n = 0; n < 40; n++) begin
      logic [1:0] c;
      logic [23:0] ad;
      case ($urandom_range(0, 2))
        0: c = C_WRITE;
        1: c = C_READ;
        default: c = C_POLL;
      endcase
      case ($urandom_range(0, 3))
        0: ad = A_WR[25:2];
        1: ad = A_RD[25:2];
        2: ad = 24'h00_0010;
        default: ad = 24'($urandom);
      endcase
      run_cmd(c, ad, $urandom, 4'($urandom), int'($urandom_range(0, 5)),
              1'($urandom_range(0, 7) == 0), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
